// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for the parametrised synchronous FIFO.
// master drives requests and write data; slave is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  clear;
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, w_en, r_en, data_in,
        input  data_out, full, empty, almost_full,
        input  almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, w_en, r_en, data_in,
        output data_out, full, empty, almost_full,
        output almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, counter-based occupancy,
// programmable thresholds, error pulses, flush and optional FWFT read.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
        $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_rd_acc;
    logic w_wr_acc;

    // Wrap by explicit compare so non power-of-2 depths work.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_ok  = bus.r_en & ~w_empty;
    assign w_wr_ok  = bus.w_en & (~w_full | w_rd_ok);
    assign w_rd_acc = w_rd_ok & ~bus.clear;
    assign w_wr_acc = w_wr_ok & ~bus.clear;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
            r_ovf <= bus.w_en & ~w_wr_ok;
            r_unf <= bus.r_en & ~w_rd_ok;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_dout;

        // Nonblocking read sees the pre-write entry on a full read+write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout <= '0;
            end else if (bus.clear) begin
                r_dout <= '0;
            end else if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr];
            end
        end

        assign bus.data_out = r_dout;
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed vector table plus queue-model
// random phases over three configurations (16/reg, 6/reg, 4/FWFT).
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) ifa ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(6))  ifb ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(4))  ifc ();

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(6)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );
    sync_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3),
        .AE_LEVEL(1), .FWFT(1)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );

    typedef struct {
        bit         clr;
        bit         w;
        bit         r;
        logic [7:0] d;
        int         cnt;
        bit         full;
        bit         empty;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         unf;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];
    int errors = 0;
    int checks = 0;
    int cur = 0;

    // Reference model: occupancy is just the queue length.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit m_ovf, m_unf;
    int m_depth, m_af, m_ae, m_fwft;

    task automatic drive(bit clr, bit w, bit r, logic [7:0] d);
        ifa.clear = (cur == 0) && clr;
        ifa.w_en = (cur == 0) && w;
        ifa.r_en = (cur == 0) && r;
        ifa.data_in = d;
        ifb.clear = (cur == 1) && clr;
        ifb.w_en = (cur == 1) && w;
        ifb.r_en = (cur == 1) && r;
        ifb.data_in = d;
        ifc.clear = (cur == 2) && clr;
        ifc.w_en = (cur == 2) && w;
        ifc.r_en = (cur == 2) && r;
        ifc.data_in = d;
    endtask

    task automatic model_edge(bit clr, bit w, bit r, logic [7:0] d);
        bit rd, wr;
        logic [7:0] tmp;
        if (clr) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
            if (m_fwft == 0) m_dout = 8'h00;
        end else begin
            rd = r && (mq.size() > 0);
            wr = w && ((mq.size() < m_depth) || rd);
            if (rd) begin
                tmp = mq.pop_front();
                if (m_fwft == 0) m_dout = tmp;
            end
            if (wr) mq.push_back(d);
            m_ovf = w && !wr;
            m_unf = r && !rd;
        end
    endtask

    task automatic step(bit clr, bit w, bit r, logic [7:0] d);
        drive(clr, w, r, d);
        @(posedge clk);
        model_edge(clr, w, r, d);
        #1;
        drive(0, 0, 0, 8'h00);
    endtask

    task automatic sample(output logic [10:0] st,
                          output logic [7:0] dout);
        case (cur)
            0: begin
                st = {5'(ifa.count), ifa.full, ifa.empty,
                      ifa.almost_full, ifa.almost_empty,
                      ifa.overflow, ifa.underflow};
                dout = ifa.data_out;
            end
            1: begin
                st = {5'(ifb.count), ifb.full, ifb.empty,
                      ifb.almost_full, ifb.almost_empty,
                      ifb.overflow, ifb.underflow};
                dout = ifb.data_out;
            end
            default: begin
                st = {5'(ifc.count), ifc.full, ifc.empty,
                      ifc.almost_full, ifc.almost_empty,
                      ifc.overflow, ifc.underflow};
                dout = ifc.data_out;
            end
        endcase
    endtask

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] pack(int c, bit f, bit e,
                                         bit af, bit ae,
                                         bit o, bit u);
        return {5'(c), f, e, af, ae, o, u};
    endfunction

    task automatic check_model(string tag);
        logic [10:0] st;
        logic [7:0] dout, edout;
        int n;
        n = mq.size();
        sample(st, dout);
        check({tag, " status"}, 32'(st),
              32'(pack(n, n == m_depth, n == 0, n >= m_af,
                       n <= m_ae, m_ovf, m_unf)));
        if (m_fwft != 0) edout = (n > 0) ? mq[0] : 8'h00;
        else edout = m_dout;
        check({tag, " dout"}, 32'(dout), 32'(edout));
    endtask

    task automatic do_reset(int which);
        cur = which;
        m_depth = (which == 0) ? 16 : (which == 1) ? 6 : 4;
        m_af = (which == 2) ? 3 : m_depth - 2;
        m_ae = (which == 2) ? 1 : 2;
        m_fwft = (which == 2) ? 1 : 0;
        drive(0, 0, 0, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        mq.delete();
        m_dout = 8'h00;
        m_ovf = 0;
        m_unf = 0;
    endtask

    function automatic void add(bit clr, bit w, bit r, logic [7:0] d,
                                int c, bit ovf, bit unf,
                                logic [7:0] dout);
        vec_t v;
        v.clr = clr; v.w = w; v.r = r; v.d = d;
        v.cnt = c;
        v.full = (c == 16);
        v.empty = (c == 0);
        v.af = (c >= 14);
        v.ae = (c <= 2);
        v.ovf = ovf; v.unf = unf; v.dout = dout;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [10:0] st;
        logic [7:0] dout;
        bit w, r, c;

        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00);

        // Fill, overflow, drain, underflow, boundary read+write.
        for (int i = 0; i < 16; i++) add(0, 1, 0, 8'(i + 1), i + 1, 0, 0, 8'h00);
        add(0, 1, 0, 8'h11, 16, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 16, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) add(0, 0, 1, 8'h00, 15 - i, 0, 0, 8'(i + 1));
        add(0, 0, 1, 8'h00, 0, 0, 1, 8'h10);
        add(0, 0, 0, 8'h00, 0, 0, 0, 8'h10);
        add(0, 1, 1, 8'h77, 1, 0, 1, 8'h10);
        for (int i = 0; i < 15; i++) add(0, 1, 0, 8'h80 + 8'(i), i + 2, 0, 0, 8'h10);
        add(0, 1, 1, 8'h99, 16, 0, 0, 8'h77);
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 8'h00, 15 - i, 0, 0, (i < 15) ? 8'h80 + 8'(i) : 8'h99);

        do_reset(0);
        sample(st, dout);
        check("reset status", 32'(st), 32'(pack(0, 0, 1, 0, 1, 0, 0)));
        check("reset dout", 32'(dout), 32'h0);
        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].w, tbl[i].r, tbl[i].d);
            sample(st, dout);
            check($sformatf("vec%0d status", i), 32'(st),
                  32'(pack(tbl[i].cnt, tbl[i].full, tbl[i].empty,
                           tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].unf)));
            check($sformatf("vec%0d dout", i), 32'(dout), 32'(tbl[i].dout));
        end

        // DEPTH=6 wrap-around, occupancy kept within 1..6.
        do_reset(1);
        step(0, 1, 0, 8'($urandom));
        check_model("wrap first");
        for (int i = 0; i < 100; i++) begin
            w = 1'($urandom);
            r = 1'($urandom);
            if (mq.size() <= 1 && r && !w) r = 0;
            if (mq.size() == 6 && w && !r) w = 0;
            step(0, w, r, 8'($urandom));
            check_model("wrap");
        end
        for (int i = 0; i < 200; i++) begin
            c = ($urandom_range(0, 15) == 0);
            step(c, 1'($urandom), 1'($urandom), 8'($urandom));
            check_model("rand6");
        end

        // FWFT head visibility and pop.
        do_reset(2);
        check_model("fwft reset");
        step(0, 1, 0, 8'hA5);
        sample(st, dout);
        check("fwft head", 32'(dout), 32'hA5);
        check("fwft cnt1", 32'(st), 32'(pack(1, 0, 0, 0, 1, 0, 0)));
        step(0, 0, 1, 8'h00);
        sample(st, dout);
        check("fwft pop dout", 32'(dout), 32'h0);
        check("fwft pop empty", 32'(st), 32'(pack(0, 0, 1, 0, 1, 0, 0)));
        for (int i = 0; i < 150; i++) begin
            c = ($urandom_range(0, 19) == 0);
            step(c, 1'($urandom), 1'($urandom), 8'($urandom));
            check_model("fwft rand");
        end

        // Flush beats simultaneous read and write.
        do_reset(0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h30 + 8'(i));
        check_model("pre-clear");
        step(1, 1, 1, 8'h3C);
        sample(st, dout);
        check("clear status", 32'(st), 32'(pack(0, 0, 1, 0, 1, 0, 0)));
        check("clear dout", 32'(dout), 32'h0);
        step(0, 0, 1, 8'h00);
        sample(st, dout);
        check("post-clear read", 32'(st), 32'(pack(0, 0, 1, 0, 1, 0, 1)));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h50 + 8'(i));
        step(0, 0, 1, 8'h00);
        check_model("pre-reset");

        // Asynchronous reset between edges while writing.
        drive(0, 1, 0, 8'h44);
        #2 rst_n = 1'b0;
        #1;
        sample(st, dout);
        check("async rst status", 32'(st), 32'(pack(0, 0, 1, 0, 1, 0, 0)));
        check("async rst dout", 32'(dout), 32'h0);
        drive(0, 0, 0, 8'h00);
        #1 rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
